// File: rtl/fpu_pkg.sv
// fpu_pkg
//    Shared constants and types for the FPU result path.
//    - EXPO_BITS_*, MANT_BITS_*, BIAS_* : IEEE-754 field widths and bias for
//      the 32-bit and 64-bit formats, plus lookup functions keyed by width.
//    - fpu_entry_t : one queue entry {ovf, unf, data}. The data field is sized
//      for the widest legal format; narrower results are zero-extended.
package fpu_pkg;

   localparam int FPU_MAX_X     = 64;

   localparam int EXPO_BITS_32  = 8;
   localparam int MANT_BITS_32  = 23;
   localparam int BIAS_32       = 127;
   localparam int EXPO_BITS_64  = 11;
   localparam int MANT_BITS_64  = 52;
   localparam int BIAS_64       = 1023;

   function automatic int expo_bits(input int x);
      return (x == 64) ? EXPO_BITS_64 : EXPO_BITS_32;
   endfunction

   function automatic int mant_bits(input int x);
      return (x == 64) ? MANT_BITS_64 : MANT_BITS_32;
   endfunction

   function automatic int bias(input int x);
      return (x == 64) ? BIAS_64 : BIAS_32;
   endfunction

   typedef logic [FPU_MAX_X-1:0] fpu_data_t;

   typedef struct packed {
      logic      ovf;
      logic      unf;
      fpu_data_t data;
   } fpu_entry_t;

endpackage

// File: rtl/fpu_queue_mem.sv
// fpu_queue_mem
//    DEPTH x fpu_entry_t storage, one synchronous write port and one
//    asynchronous read port. Contents are not reset.
//    Ports:
//       clk      : clock, write on rising edge
//       wr_en    : write strobe
//       wr_addr  : write slot
//       wr_entry : entry to write
//       rd_addr  : read slot
//       rd_entry : entry at rd_addr (combinational)
module fpu_queue_mem
   import fpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  fpu_entry_t    wr_entry,
   input  logic [AW-1:0] rd_addr,
   output fpu_entry_t    rd_entry
);

   fpu_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_entry;
      end
   end

   assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/fpu_result_queue.sv
// fpu_result_queue
//    FIFO for multiplier results with per-entry overflow/underflow flags and
//    sticky summary flags. Strict FIFO order, no bypass: a pushed entry is
//    visible on the output one cycle after the push.
//    Ports:
//       clk, rst                  : clock, async active-high reset
//       in_valid/in_ready         : push handshake; in_ready also high on a
//                                   full queue when out_ready pops this cycle
//       in_data, in_overflow,
//       in_underflow              : entry stored unmodified
//       out_valid/out_ready       : pop handshake
//       out_data, out_overflow,
//       out_underflow             : head entry; holds last head when empty
//       sticky_ovf, sticky_unf    : set on accepted flagged push
//       flag_clear                : sync clear of sticky flags (wins over set)
//       level                     : occupancy 0..DEPTH
//       result_count              : pop counter, only with FPU_RESULT_COUNT_EN
//    Build option: define FPU_RESULT_COUNT_EN to add result_count.
module fpu_result_queue
   import fpu_pkg::*;
#(
   parameter  int X     = 32,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [X-1:0]  in_data,
   input  logic          in_overflow,
   input  logic          in_underflow,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [X-1:0]  out_data,
   output logic          out_overflow,
   output logic          out_underflow,
   output logic          sticky_ovf,
   output logic          sticky_unf,
   input  logic          flag_clear,
   output logic [PW:0]   level
`ifdef FPU_RESULT_COUNT_EN
   ,
   output logic [31:0]   result_count
`endif
);

   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   fpu_entry_t    wr_entry;
   fpu_entry_t    rd_entry;
   fpu_entry_t    hold_q;
   fpu_entry_t    head;

   assign in_ready  = (level != FULL) || out_ready;
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_entry      = '0;
      wr_entry.ovf  = in_overflow;
      wr_entry.unf  = in_underflow;
      wr_entry.data = fpu_data_t'(in_data);
   end

   fpu_queue_mem #(.DEPTH(DEPTH)) u_mem (
      .clk      (clk),
      .wr_en    (push),
      .wr_addr  (wr_ptr),
      .wr_entry (wr_entry),
      .rd_addr  (rd_ptr),
      .rd_entry (rd_entry)
   );

   // When empty the output shows the entry most recently popped (zero after
   // reset) rather than whatever stale slot rd_ptr now points at.
   assign head          = out_valid ? rd_entry : hold_q;
   assign out_data      = head.data[X-1:0];
   assign out_overflow  = head.ovf;
   assign out_underflow = head.unf;

   generate
      if (X < FPU_MAX_X) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^head.data[FPU_MAX_X-1:X];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         hold_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            hold_q <= rd_entry;
         end
         case ({push, pop})
            2'b10:   level <= level + (PW+1)'(1);
            2'b01:   level <= level - (PW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
      end else if (flag_clear) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
      end else if (push) begin
         sticky_ovf <= sticky_ovf | in_overflow;
         sticky_unf <= sticky_unf | in_underflow;
      end
   end

`ifdef FPU_RESULT_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_count <= '0;
      end else if (flag_clear) begin
         result_count <= '0;
      end else if (pop) begin
         result_count <= result_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
module tb_fpu_result_queue;

   localparam int X     = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [X-1:0]  in_data;
   logic          in_overflow;
   logic          in_underflow;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [X-1:0]  out_data;
   logic          out_overflow;
   logic          out_underflow;
   logic          sticky_ovf;
   logic          sticky_unf;
   logic          flag_clear;
   logic [LW-1:0] level;
`ifdef FPU_RESULT_COUNT_EN
   logic [31:0]   result_count;
`endif

   fpu_result_queue #(.X(X), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_overflow   (in_overflow),
      .in_underflow  (in_underflow),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .sticky_ovf    (sticky_ovf),
      .sticky_unf    (sticky_unf),
      .flag_clear    (flag_clear),
      .level         (level)
`ifdef FPU_RESULT_COUNT_EN
      ,
      .result_count  (result_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic         ovf;
      logic         unf;
      logic [X-1:0] data;
   } ent_t;

   ent_t        sb[$];
   ent_t        last_head;
   bit          m_sovf;
   bit          m_sunf;
   int unsigned m_cnt;
   int          vectors;
   int          miscompares;

   function automatic ent_t exp_head();
      return (sb.size() != 0) ? sb[0] : last_head;
   endfunction

   task automatic model_clear();
      sb.delete();
      last_head = '0;
      m_sovf    = 1'b0;
      m_sunf    = 1'b0;
      m_cnt     = 0;
   endtask

   task automatic set_in(input bit v, input logic [X-1:0] d, input bit o,
                         input bit u, input bit r, input bit c);
      in_valid     = v;
      in_data      = d;
      in_overflow  = o;
      in_underflow = u;
      out_ready    = r;
      flag_clear   = c;
   endtask

   // Advances one clock and updates the reference model from the inputs
   // held across that edge. Returns at the following falling edge.
   task automatic tick();
      bit   mpush;
      bit   mpop;
      ent_t e;
      mpush = in_valid && ((sb.size() != DEPTH) || out_ready);
      mpop  = (sb.size() != 0) && out_ready;
      e.ovf  = in_overflow;
      e.unf  = in_underflow;
      e.data = in_data;
      @(posedge clk);
      if (mpop) begin
         last_head = sb.pop_front();
         m_cnt++;
      end
      if (mpush) sb.push_back(e);
      if (flag_clear) begin
         m_sovf = 1'b0;
         m_sunf = 1'b0;
         m_cnt  = 0;
      end else if (mpush) begin
         m_sovf = m_sovf | e.ovf;
         m_sunf = m_sunf | e.unf;
      end
      @(negedge clk);
   endtask

   task automatic drain_and_check(input string tag);
      ent_t h;
      int   guard;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         h = exp_head();
         vectors++;
         if ({out_valid, out_overflow, out_underflow, out_data} !== {1'b1, h.ovf, h.unf, h.data}) begin
            miscompares++;
            $display("FAIL %s_drain: got v=%b o=%b u=%b d=%h want v=1 o=%b u=%b d=%h",
                     tag, out_valid, out_overflow, out_underflow, out_data, h.ovf, h.unf, h.data);
         end
         tick();
         guard++;
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || level !== '0) begin
         miscompares++;
         $display("FAIL %s_empty: got v=%b level=%0d want v=0 level=0", tag, out_valid, level);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      @(negedge clk);
      vectors++;
      if ({level, out_valid, in_ready, sticky_ovf, sticky_unf} !== {LW'(0), 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got level=%0d v=%b rdy=%b so=%b su=%b want 0 0 1 0 0",
                  level, out_valid, in_ready, sticky_ovf, sticky_unf);
      end
      vectors++;
      if (out_data !== '0) begin
         miscompares++;
         $display("FAIL reset_out_data: got %h want 0", out_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      set_in(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_first: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      tick();
      set_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h4040_0000) begin
         miscompares++;
         $display("FAIL basic_visible: got v=%b d=%h want v=1 d=40400000", out_valid, out_data);
      end
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if ({level, out_valid, out_data} !== {LW'(2), 1'b1, 32'h4040_0000}) begin
         miscompares++;
         $display("FAIL basic_two: got level=%0d v=%b d=%h want 2 1 40400000", level, out_valid, out_data);
      end
      drain_and_check("basic");
      vectors++;
      if (out_data !== 32'h3F80_0000) begin
         miscompares++;
         $display("FAIL basic_hold: got %h want 3f800000", out_data);
      end
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 32'h1000_0000 + X'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (level !== LW'(4) || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_state: got level=%0d rdy=%b want 4 0", level, in_ready);
      end
      set_in(1'b1, 32'h1000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_data !== 32'h1000_0000) begin
         miscompares++;
         $display("FAIL full_pushpop_rdy: got rdy=%b d=%h want 1 10000000", in_ready, out_data);
      end
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (level !== LW'(4) || out_data !== 32'h1000_0001) begin
         miscompares++;
         $display("FAIL full_pushpop_after: got level=%0d d=%h want 4 10000001", level, out_data);
      end
      drain_and_check("full");
   endtask

   task automatic test_sticky();
      set_in(1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (sticky_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL sticky_early: got %b want 0", sticky_ovf);
      end
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if ({sticky_ovf, sticky_unf, out_overflow} !== {m_sovf, m_sunf, 1'b1} || m_sovf !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_ovf_set: got so=%b su=%b oo=%b want 1 0 1", sticky_ovf, sticky_unf, out_overflow);
      end
      set_in(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (sticky_unf !== 1'b1 || sticky_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_unf_set: got so=%b su=%b want 1 1", sticky_ovf, sticky_unf);
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
         miscompares++;
         $display("FAIL sticky_clear: got so=%b su=%b want 0 0", sticky_ovf, sticky_unf);
      end
      set_in(1'b1, 32'hFF80_0000, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (sticky_ovf !== 1'b0 || level !== LW'(3)) begin
         miscompares++;
         $display("FAIL sticky_clear_prio: got so=%b level=%0d want 0 3", sticky_ovf, level);
      end
      drain_and_check("sticky");
   endtask

   task automatic test_random();
      logic [X-1:0] words [10];
      int pushed;
      int pops;
      int cyc;
      bit r;
      bit v;
      bit o;
      bit u;
      for (int i = 0; i < 10; i++) words[i] = $urandom;
      words[3] = 32'h7FC0_0001;
      words[7] = 32'hFFFF_FFFF;
      pushed = 0;
      pops   = 0;
      cyc    = 0;
      while ((pushed < 10 || sb.size() != 0) && cyc < 200) begin
         v = (pushed < 10);
         r = 1'($urandom_range(0, 1));
         o = 1'(words[pushed % 10][0]);
         u = 1'(words[pushed % 10][1]);
         set_in(v, words[pushed % 10], o, u, r, 1'b0);
         #1;
         vectors++;
         if ({level, out_valid, in_ready} !== {LW'(sb.size()), sb.size() != 0,
                                               (sb.size() != DEPTH) || r}) begin
            miscompares++;
            $display("FAIL random_ctl: cyc=%0d got level=%0d v=%b rdy=%b want level=%0d",
                     cyc, level, out_valid, in_ready, sb.size());
         end
         if (sb.size() != 0 && r) begin
            vectors++;
            if ({out_overflow, out_underflow, out_data} !== {sb[0].ovf, sb[0].unf, sb[0].data}) begin
               miscompares++;
               $display("FAIL random_order: got %b%b %h want %b%b %h", out_overflow, out_underflow,
                        out_data, sb[0].ovf, sb[0].unf, sb[0].data);
            end
            pops++;
         end
         if (v && ((sb.size() != DEPTH) || r)) pushed++;
         tick();
         cyc++;
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (pops != 10 || cyc >= 200) begin
         miscompares++;
         $display("FAIL random_done: got pops=%0d cycles=%0d want pops=10 within 200", pops, cyc);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'hA000_0000 + X'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      rst = 1'b1;
      model_clear();
      #1;
      vectors++;
      if ({out_valid, level, in_ready, out_data} !== {1'b0, LW'(0), 1'b1, X'(0)}) begin
         miscompares++;
         $display("FAIL midreset_state: got v=%b level=%0d rdy=%b d=%h want 0 0 1 0",
                  out_valid, level, in_ready, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if ({level, out_data, out_underflow} !== {LW'(1), 32'hDEAD_BEEF, 1'b1}) begin
         miscompares++;
         $display("FAIL midreset_push: got level=%0d d=%h u=%b want 1 deadbeef 1",
                  level, out_data, out_underflow);
      end
      drain_and_check("midreset");
   endtask

`ifdef FPU_RESULT_COUNT_EN
   task automatic test_count();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, X'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (result_count !== 32'd5 || m_cnt != 5) begin
         miscompares++;
         $display("FAIL count_five: got %0d want 5", result_count);
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (result_count !== 32'd0) begin
         miscompares++;
         $display("FAIL count_clear: got %0d want 0", result_count);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_full_pushpop();
      test_sticky();
      test_random();
      test_reset_mid();
`ifdef FPU_RESULT_COUNT_EN
      test_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fpu_result_queue.md
FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 Parameter X, default 32, operand/result width; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 4, queue entries; must be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  multiplier result present this cycle.
REQ-006 in_data  input  X  multiplier result word (sign, exponent, mantissa).
REQ-007 in_overflow  input  1  multiplier overflow flag for in_data.
REQ-008 in_underflow  input  1  multiplier underflow flag for in_data.
REQ-009 in_ready  output  1  queue can accept an entry this cycle.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head this cycle.
REQ-012 out_data  output  X  head result word.
REQ-013 out_overflow  output  1  head entry overflow flag.
REQ-014 out_underflow  output  1  head entry underflow flag.
REQ-015 sticky_ovf  output  1  set when any overflow entry is accepted; held until cleared.
REQ-016 sticky_unf  output  1  set when any underflow entry is accepted; held until cleared.
REQ-017 flag_clear  input  1  synchronous clear of both sticky flags.
REQ-018 level  output  log2(DEPTH)+1  current occupancy.

Function
REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-020 Each entry stores {in_overflow, in_underflow, in_data} unmodified.
REQ-021 in_ready = (level != DEPTH) || out_ready, so a push is allowed on a full queue when a pop occurs in the same cycle.
REQ-022 out_valid = (level != 0); there is no bypass, and a pushed entry is visible one cycle after the push.
REQ-023 out_data, out_overflow and out_underflow are driven combinationally from the head slot; when empty they hold the last head value.
REQ-024 Push and pop in the same cycle leave level unchanged and advance both pointers.
REQ-025 Read and write pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-026 Push when full without a pop is impossible by construction; a pop when empty is ignored.
REQ-027 Sticky flags set on the accepted push cycle; flag_clear has priority over a same-cycle set.
REQ-028 Output ordering is strict FIFO, and no entry is dropped or duplicated.
REQ-029 X bits in in_data, such as NaN payloads, are stored and forwarded as-is, with no interpretation.

Reset
REQ-030 On rst: pointers = 0, level = 0, out_valid = 0, in_ready = 1, sticky_ovf = 0, sticky_unf = 0, storage contents undefined, out_data = 0.
REQ-031 Reset asserted mid-operation discards all entries immediately, and the first push after deassertion lands in slot 0.

Configuration
REQ-032 Macro FPU_RESULT_COUNT_EN is the compile-time switch for a result counter.
REQ-033 With FPU_RESULT_COUNT_EN: add output result_count (32 bits), incremented on every pop, wrapping at 2^32-1 to 0, reset to 0, and cleared by flag_clear.
REQ-034 Without FPU_RESULT_COUNT_EN: the result_count port and its logic are absent, and all other behaviour is identical.

Structure
REQ-035 Shared package fpu_pkg holds width-derived constants EXPO_BITS, MANT_BITS, BIAS for X = 32/64 and the entry struct {ovf, unf, data}.
REQ-036 One sub-module, fpu_queue_mem (DEPTH x entry, one write port, one asynchronous read port), is instantiated for storage; pointer and flag control stays in the top level.

Verification
REQ-037 After reset, push 0x40400000, then 0x3F800000, with out_ready=0 -> level=2, out_valid=1, out_data=0x40400000.
REQ-038 Fill 4 entries, then in_valid=1 and out_ready=1 for one cycle -> push and pop both occur, level stays 4, head advances.
REQ-039 Push a word with in_overflow=1 (out=0x7FC00000) -> sticky_ovf=1 next cycle; pulse flag_clear -> 0; flag_clear together with an overflow push -> 0.
REQ-040 Push 10 words with a random out_ready pattern -> the output sequence equals the input sequence and pointer wrap is exercised.
REQ-041 Assert rst with 3 entries queued -> out_valid=0 and level=0 immediately; the next push is read back correctly.
REQ-042 With FPU_RESULT_COUNT_EN defined, 5 pops -> result_count=5; flag_clear -> 0.
